// File: rtl/fir_pkg.sv
// Shared definitions for the forward FIR and its recursive inverse:
// FSM states, default taps and the sample-narrowing helpers.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  localparam int DEFAULT_TAPS = 4;
  localparam int DEFAULT_COEF [DEFAULT_TAPS] = '{1, 2, 2, 1};

  // h[0] is always 1; the {1,2,2,1} kernel applies only to the 4-tap build.
  function automatic int fir_default_coef(input int n, input int k);
    if (k == 0) return 1;
    if (n == DEFAULT_TAPS && k < DEFAULT_TAPS) return DEFAULT_COEF[k];
    return 0;
  endfunction

  // Callers keep the low w bits; with sat clear this is a plain wrap.
  function automatic logic signed [63:0] fir_narrow(input logic signed [63:0] v,
                                                    input int w, input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (sat && v > hi) return hi;
    if (sat && v < lo) return lo;
    return v;
  endfunction

  function automatic logic fir_clips(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/fir_inv_mac.sv
// Registered multiply-subtract accumulator: load seeds acc with z,
// each step subtracts h*y_hist at full product precision.
module fir_inv_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = 2*DATA_WIDTH+2,
  parameter int ACC_WIDTH  = IN_WIDTH+4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         step,
  input  logic signed [IN_WIDTH-1:0]   z,
  input  logic signed [DATA_WIDTH-1:0] h,
  input  logic signed [DATA_WIDTH-1:0] y_hist,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] product;

  assign product = h * y_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_WIDTH'(z);
    end else if (step) begin
      acc <= acc - ACC_WIDTH'(product);
    end
  end

endmodule

// File: rtl/fir_inverse_filter.sv
// All-pole inverse of the direct-form FIR, one MAC per clock.
// Define FIR_INV_SAT_EN for saturating narrowing and the sat_flag port.
module fir_inverse_filter
  import fir_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = 2*DATA_WIDTH+2,
  parameter int ACC_WIDTH  = IN_WIDTH+4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [IN_WIDTH-1:0]   z_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] y_out,
  input  logic                         coef_we,
  input  logic [$clog2(N)-1:0]         coef_addr,
  input  logic signed [DATA_WIDTH-1:0] coef_data,
  output logic                         busy
`ifdef FIR_INV_SAT_EN
  ,output logic                        sat_flag
`endif
);

  localparam int KW = $clog2(N);
`ifdef FIR_INV_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  fir_state_t                   state;
  logic [KW-1:0]                k;
  logic signed [DATA_WIDTH-1:0] coef [N];
  logic signed [DATA_WIDTH-1:0] hist [N-1];
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0] h_sel;
  logic signed [DATA_WIDTH-1:0] y_sel;
  logic                         accept;

  assign in_ready = (state == IDLE) && !coef_we;
  assign accept   = in_valid && in_ready;
  assign h_sel    = coef[k];
  assign y_sel    = (k == '0) ? '0 : hist[k - 1'b1];

  // acc is frozen throughout OUT, so the narrowed value is stable while out_valid is high.
  always_comb begin
    y_out = DATA_WIDTH'(fir_narrow(64'(acc), DATA_WIDTH, SAT));
  end

`ifdef FIR_INV_SAT_EN
  assign sat_flag = out_valid && fir_clips(64'(acc), DATA_WIDTH);
`endif

  fir_inv_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .step  (state == MAC),
    .z     (z_in),
    .h     (h_sel),
    .y_hist(y_sel),
    .acc   (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            k     <= KW'(1);
            state <= MAC;
            busy  <= 1'b1;
          end
        end
        MAC: begin
          if (k == KW'(N - 1)) begin
            k         <= '0;
            state     <= OUT;
            out_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // History holds the narrowed output so the recursion matches the FIR input exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) coef[i] <= DATA_WIDTH'(fir_default_coef(N, i));
      for (int i = 0; i < N - 1; i++) hist[i] <= '0;
    end else begin
      if (state == IDLE && coef_we) begin
        for (int i = 1; i < N; i++) begin
          if (coef_addr == KW'(i)) coef[i] <= coef_data;
        end
      end
      if (state == OUT && out_ready) begin
        hist[0] <= y_out;
        for (int i = 1; i < N - 1; i++) hist[i] <= hist[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fir_inverse_filter.sv
// Directed-vector bench for fir_inverse_filter with hand-computed expectations;
// follows FIR_INV_SAT_EN to pick the narrowing expectation.
module tb_fir_inverse_filter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2*DW+2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] z_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] y_out;
  logic                 coef_we;
  logic [1:0]           coef_addr;
  logic signed [DW-1:0] coef_data;
  logic                 busy;
`ifdef FIR_INV_SAT_EN
  logic                 sat_flag;
`endif

  int vectors = 0;
  int miscompares = 0;

  fir_inverse_filter #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y_out    (y_out),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .busy     (busy)
`ifdef FIR_INV_SAT_EN
    ,.sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sample: accept, optional write attempt during MAC, latency, stall, handshake.
  task automatic applyStimulus(input string tag, input int z, input int exp_y,
                               input int stall, input bit mid_write, input int exp_sat);
    int wait_cycles;
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    z_in      = IW'(z);
    wait_cycles = 0;
    while (!in_ready && wait_cycles < 20) begin
      tick();
      wait_cycles++;
    end
    if (!in_ready) checkOutput({tag, "_acceptTimeout"}, 0, 1);
    tick();
    in_valid = 1'b0;
    checkOutput({tag, "_busy"}, int'(busy), 1);
    if (mid_write) begin
      coef_we   = 1'b1;
      coef_addr = 2'd1;
      coef_data = 8'sd9;
    end
    wait_cycles = 0;
    while (!out_valid && wait_cycles < 20) begin
      tick();
      coef_we = 1'b0;
      wait_cycles++;
    end
    coef_we = 1'b0;
    checkOutput({tag, "_latency"}, wait_cycles, N - 1);
    for (int i = 0; i < stall; i++) begin
      checkOutput({tag, "_stallValid"}, int'(out_valid), 1);
      checkOutput({tag, "_stallY"}, int'(y_out), exp_y);
      checkOutput({tag, "_stallReady"}, int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    checkOutput({tag, "_y"}, int'(y_out), exp_y);
`ifdef FIR_INV_SAT_EN
    checkOutput({tag, "_sat"}, int'(sat_flag), exp_sat);
`else
    if (exp_sat < 0) checkOutput({tag, "_satArg"}, exp_sat, 0);
`endif
    tick();
    checkOutput({tag, "_validDrop"}, int'(out_valid), 0);
    checkOutput({tag, "_readyBack"}, int'(in_ready), 1);
  endtask

  task automatic writeCoef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = 2'(addr);
    coef_data = DW'(data);
    #1;
    checkOutput("coefWriteBlocksReady", int'(in_ready), 0);
    tick();
    coef_we = 1'b0;
  endtask

  initial begin
    int narrow_y;
    reset     = 1'b1;
    in_valid  = 1'b0;
    z_in      = '0;
    out_ready = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    tick();
    tick();
    checkOutput("rstValid", int'(out_valid), 0);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstY", int'(y_out), 0);
    reset = 1'b0;
    tick();
    checkOutput("rstReady", int'(in_ready), 1);

    // Impulse through the default {1,2,2,1} kernel inverts to a single 1.
    applyStimulus("imp0", 1, 1, 0, 1'b0, 0);
    applyStimulus("imp1", 2, 0, 0, 1'b0, 0);
    applyStimulus("imp2", 2, 0, 0, 1'b0, 0);
    applyStimulus("imp3", 1, 0, 0, 1'b0, 0);
    applyStimulus("imp4", 0, 0, 0, 1'b0, 0);

    applyStimulus("rt0", 3, 3, 0, 1'b0, 0);
    applyStimulus("rt1", 5, -1, 0, 1'b0, 0);
    applyStimulus("rt2", 9, 5, 0, 1'b0, 0);
    applyStimulus("rt3", 11, 0, 0, 1'b0, 0);

    // History {0,5,-1}: 19-0-10+1 = 10, then history {10,0,5}: 25-20-0-5 = 0.
    applyStimulus("bp0", 19, 10, 5, 1'b0, 0);
    applyStimulus("bp1", 25, 0, 0, 1'b0, 0);

    writeCoef(1, 0);
    writeCoef(2, 0);
    writeCoef(3, 0);
    writeCoef(0, 5);
    applyStimulus("cw0", 7, 7, 0, 1'b0, 0);
    applyStimulus("cw1", -4, -4, 0, 1'b1, 0);
    applyStimulus("cw2", 3, 3, 0, 1'b0, 0);

`ifdef FIR_INV_SAT_EN
    narrow_y = 127;
`else
    narrow_y = -56;
`endif
    applyStimulus("narrow", 200, narrow_y, 0, 1'b0, 1);

    in_valid = 1'b1;
    z_in     = IW'(5);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    checkOutput("abortValid", int'(out_valid), 0);
    checkOutput("abortReady", int'(in_ready), 1);
    checkOutput("abortBusy", int'(busy), 0);
    applyStimulus("post0", 1, 1, 0, 1'b0, 0);
    applyStimulus("post1", 2, 0, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
